// File: rtl/di_reg_bank.sv
// Device-interface register bank: NUM_REGS control registers plus one FIFO-backed streaming read address.
// Read data appears one cycle after LOAD, then one word per clock; stream reads stall on an empty FIFO.

module sync_fifo #(
  parameter int DW = 16,
  parameter int AW = 9
) (
  input  logic          if_clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] pop_dat,
  output logic [AW:0]   count,
  output logic          empty
);
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // The caller never pushes when full nor pops when empty.
  always_ff @(posedge if_clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge if_clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign empty   = (count == '0);
endmodule

module di_reg_bank #(
  parameter logic [15:0]         EP_ADDR     = 16'h0001,
  parameter int                  NUM_REGS    = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter logic [15:0]         STREAM_ADDR = 16'h00FF,
  parameter int                  FIFO_AW     = 9
) (
  input  logic                     if_clock,
  input  logic                     reset,
  input  logic [15:0]              diEpAddr,
  input  logic [15:0]              diRegAddr,
  input  logic [15:0]              diRegDataIn,
  input  logic                     diWrite,
  input  logic                     diRead,
  input  logic                     diReset,
  output logic [15:0]              diRegDataOut,
  output logic                     rd_ready,
  output logic                     wr_ready,
  output logic [16*NUM_REGS-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      reg_wstrobe,
  input  logic [16*NUM_REGS-1:0]   ro_in,
  input  logic [15:0]              stream_data,
  input  logic                     stream_valid,
  output logic                     stream_ready,
  output logic [FIFO_AW:0]         fifo_count,
  output logic                     fifo_overflow
);
  localparam int                IW         = $clog2(NUM_REGS);
  localparam logic [15:0]       NUM_REGS_W = 16'(NUM_REGS);
  localparam logic [FIFO_AW:0]  FIFO_DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, VALID} rd_state_t;

  logic        sel;
  logic [15:0] regs   [NUM_REGS];
  logic [15:0] rd_val [NUM_REGS];

  assign sel = (diEpAddr == EP_ADDR);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    assign reg_out[16*i +: 16] = regs[i];
    assign rd_val[i]           = RO_MASK[i] ? ro_in[16*i +: 16] : regs[i];
  end

  // ---------------- write path ----------------
  logic          diWrite_d;
  logic [15:0]   wr_ptr;
  logic [15:0]   wr_addr;
  logic [IW-1:0] wr_idx;
  logic          wr_en;
  logic [NUM_REGS-1:0] wstrobe_nxt;

  assign wr_addr = (diWrite && !diWrite_d) ? diRegAddr : wr_ptr + 16'd1;
  assign wr_idx  = wr_addr[IW-1:0];
  assign wr_en   = diWrite && sel && (wr_addr < NUM_REGS_W) && !RO_MASK[wr_idx];

  always_comb begin
    wstrobe_nxt = '0;
    if (wr_en) wstrobe_nxt[wr_idx] = 1'b1;
  end

  always_ff @(posedge if_clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wstrobe <= '0;
      diWrite_d   <= 1'b0;
      wr_ptr      <= '0;
    end else begin
      if (wr_en) regs[wr_idx] <= diRegDataIn;
      reg_wstrobe <= wstrobe_nxt;
      diWrite_d   <= diWrite;
      if (diReset)      wr_ptr <= '0;
      else if (diWrite) wr_ptr <= wr_addr;
    end
  end

  // ---------------- stream FIFO with head register ----------------
  logic             fifo_full;
  logic             mem_push;
  logic             mem_pop;
  logic             mem_empty;
  logic [15:0]      mem_dat;
  logic [FIFO_AW:0] mem_count;
  logic             head_vld;
  logic [15:0]      head_dat;
  logic             stream_pop;

  assign fifo_count   = mem_count + {{FIFO_AW{1'b0}}, head_vld};
  assign fifo_full    = (fifo_count == FIFO_DEPTH);
  assign stream_ready = !fifo_full;
  assign mem_push     = stream_valid && !fifo_full && !diReset;
  assign mem_pop      = !mem_empty && (!head_vld || stream_pop) && !diReset;

  sync_fifo #(.DW(16), .AW(FIFO_AW)) u_fifo (
    .if_clock (if_clock),
    .reset    (reset),
    .flush    (diReset),
    .push     (mem_push),
    .push_dat (stream_data),
    .pop      (mem_pop),
    .pop_dat  (mem_dat),
    .count    (mem_count),
    .empty    (mem_empty)
  );

  always_ff @(posedge if_clock) begin
    if (reset || diReset) begin
      head_vld      <= 1'b0;
      head_dat      <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      if (mem_pop) begin
        head_vld <= 1'b1;
        head_dat <= mem_dat;
      end else if (stream_pop) begin
        head_vld <= 1'b0;
      end
      if (stream_valid && fifo_full) fifo_overflow <= 1'b1;
    end
  end

  // ---------------- read FSM ----------------
  rd_state_t   state, state_nxt;
  logic        diRead_d;
  logic [15:0] rd_ptr, rd_ptr_nxt;
  logic [15:0] data_q, data_nxt;
  logic        stream_mode, stream_nxt;
  logic        fetch;
  logic [15:0] fetch_dat;

  always_comb begin
    fetch_dat = '0;
    if (rd_ptr < NUM_REGS_W) fetch_dat = rd_val[rd_ptr[IW-1:0]];
  end

  // rd_ptr always names the next word to fetch; reaching STREAM_ADDR hands over to the head register.
  always_comb begin
    state_nxt  = state;
    rd_ptr_nxt = rd_ptr;
    data_nxt   = data_q;
    stream_nxt = stream_mode;
    fetch      = 1'b0;
    stream_pop = 1'b0;
    case (state)
      IDLE: begin
        if (diRead && !diRead_d && sel) begin
          state_nxt  = LOAD;
          rd_ptr_nxt = diRegAddr;
        end
      end
      LOAD: begin
        state_nxt = VALID;
        fetch     = 1'b1;
      end
      VALID: begin
        if (!diRead)          state_nxt  = IDLE;
        else if (stream_mode) stream_pop = head_vld;
        else                  fetch      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (fetch) begin
      if (rd_ptr == STREAM_ADDR) begin
        stream_nxt = 1'b1;
      end else begin
        stream_nxt = 1'b0;
        data_nxt   = fetch_dat;
        rd_ptr_nxt = rd_ptr + 16'd1;
      end
    end
    if (!sel || diReset) begin
      state_nxt  = IDLE;
      stream_pop = 1'b0;
    end
    if (stream_pop) data_nxt = head_dat;
  end

  always_ff @(posedge if_clock) begin
    if (reset) begin
      state       <= IDLE;
      diRead_d    <= 1'b0;
      rd_ptr      <= '0;
      data_q      <= '0;
      stream_mode <= 1'b0;
    end else if (diReset) begin
      state       <= IDLE;
      diRead_d    <= diRead;
      rd_ptr      <= '0;
      stream_mode <= 1'b0;
    end else begin
      state       <= state_nxt;
      diRead_d    <= diRead;
      rd_ptr      <= rd_ptr_nxt;
      data_q      <= data_nxt;
      stream_mode <= stream_nxt;
    end
  end

  always_comb begin
    diRegDataOut = '0;
    rd_ready     = 1'b0;
    if (sel) begin
      diRegDataOut = (state == VALID && stream_mode) ? head_dat : data_q;
      rd_ready     = (state == VALID) && (!stream_mode || head_vld);
    end
  end

  assign wr_ready = sel && !reset;
endmodule

// File: tb/tb_di_reg_bank.sv
// Directed bench for di_reg_bank: register bursts, read-only and unselected access, stream FIFO stall and overflow.
module tb_di_reg_bank;
  logic         if_clock = 1'b0;
  logic         reset;
  logic [15:0]  diEpAddr, diRegAddr, diRegDataIn;
  logic         diWrite, diRead, diReset;
  logic [15:0]  diRegDataOut;
  logic         rd_ready, wr_ready;
  logic [255:0] reg_out;
  logic [15:0]  reg_wstrobe;
  logic [255:0] ro_in;
  logic [15:0]  stream_data;
  logic         stream_valid, stream_ready;
  logic [9:0]   fifo_count;
  logic         fifo_overflow;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 if_clock = ~if_clock;

  di_reg_bank #(
    .EP_ADDR(16'h0001), .NUM_REGS(16), .RO_MASK(16'h0020), .STREAM_ADDR(16'h00FF), .FIFO_AW(9)
  ) dut (
    .if_clock(if_clock), .reset(reset), .diEpAddr(diEpAddr), .diRegAddr(diRegAddr),
    .diRegDataIn(diRegDataIn), .diWrite(diWrite), .diRead(diRead), .diReset(diReset),
    .diRegDataOut(diRegDataOut), .rd_ready(rd_ready), .wr_ready(wr_ready), .reg_out(reg_out),
    .reg_wstrobe(reg_wstrobe), .ro_in(ro_in), .stream_data(stream_data),
    .stream_valid(stream_valid), .stream_ready(stream_ready), .fifo_count(fifo_count),
    .fifo_overflow(fifo_overflow)
  );

  task automatic tick();
    @(posedge if_clock);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rego(input int i);
    return reg_out[16*i +: 16];
  endfunction

  initial begin
    reset = 1'b1; diEpAddr = 16'h0001; diRegAddr = '0; diRegDataIn = '0;
    diWrite = 1'b0; diRead = 1'b0; diReset = 1'b0; stream_data = '0; stream_valid = 1'b0;
    for (int i = 0; i < 16; i++) ro_in[16*i +: 16] = 16'hDEAD;
    ro_in[16*5 +: 16] = 16'hBEEF;
    repeat (3) tick();
    check_val("rst_data",  32'(diRegDataOut), 32'h0);
    check_val("rst_rdy",   32'(rd_ready), 32'h0);
    check_val("rst_wrdy",  32'(wr_ready), 32'h0);
    check_val("rst_regs",  32'(|reg_out), 32'h0);
    check_val("rst_wstb",  32'(reg_wstrobe), 32'h0);
    check_val("rst_cnt",   32'(fifo_count), 32'h0);
    check_val("rst_ovf",   32'(fifo_overflow), 32'h0);
    reset = 1'b0;
    tick();
    check_val("wrdy_sel", 32'(wr_ready), 32'h1);

    // Burst read of regs 0..3 after reset
    diRegAddr = 16'h0000; diRead = 1'b1;
    tick();
    check_val("rd_lat_load", 32'(rd_ready), 32'h0);
    tick();
    check_val("rd_lat_valid", 32'(rd_ready), 32'h1);
    check_val("rd0", 32'(diRegDataOut), 32'h0);
    for (int k = 1; k < 4; k++) begin
      tick();
      check_val("rd_burst_rdy", 32'(rd_ready), 32'h1);
      check_val("rd_burst_dat", 32'(diRegDataOut), 32'h0);
    end
    diRead = 1'b0;
    tick();
    check_val("rd_end_rdy", 32'(rd_ready), 32'h0);

    // Write burst at address 2
    diRegAddr = 16'h0002; diRegDataIn = 16'hA5A5; diWrite = 1'b1;
    tick();
    check_val("wr_reg2", 32'(rego(2)), 32'hA5A5);
    check_val("wr_stb2", 32'(reg_wstrobe), 32'h0004);
    diRegDataIn = 16'h1234;
    tick();
    check_val("wr_reg3", 32'(rego(3)), 32'h1234);
    check_val("wr_stb3", 32'(reg_wstrobe), 32'h0008);
    diWrite = 1'b0;
    tick();
    check_val("wr_stb_off", 32'(reg_wstrobe), 32'h0);

    // Read back with auto-increment
    diRegAddr = 16'h0002; diRead = 1'b1;
    tick(); tick();
    check_val("rb_reg2", 32'(diRegDataOut), 32'hA5A5);
    tick();
    check_val("rb_reg3", 32'(diRegDataOut), 32'h1234);
    tick();
    check_val("rb_reg4", 32'(diRegDataOut), 32'h0);
    diRead = 1'b0;
    tick();

    // Write burst starting at 0xFFFF wraps to register 0
    diRegAddr = 16'hFFFF; diRegDataIn = 16'h1111; diWrite = 1'b1;
    tick();
    check_val("wrap_drop_stb", 32'(reg_wstrobe), 32'h0);
    diRegDataIn = 16'h2222;
    tick();
    check_val("wrap_reg0", 32'(rego(0)), 32'h2222);
    check_val("wrap_stb0", 32'(reg_wstrobe), 32'h0001);
    check_val("wrap_reg15", 32'(rego(15)), 32'h0);
    diWrite = 1'b0;
    tick();

    // Read-only register 5
    diRegAddr = 16'h0005; diRegDataIn = 16'h7777; diWrite = 1'b1;
    tick();
    check_val("ro_reg5", 32'(rego(5)), 32'h0);
    check_val("ro_stb", 32'(reg_wstrobe), 32'h0);
    diWrite = 1'b0;
    tick();
    diRead = 1'b1;
    tick(); tick();
    check_val("ro_rd5", 32'(diRegDataOut), 32'hBEEF);
    diRead = 1'b0;
    tick();
    check_val("hold_rdy", 32'(rd_ready), 32'h0);
    check_val("hold_dat", 32'(diRegDataOut), 32'hBEEF);

    // Address past NUM_REGS that is not the stream address reads zero
    diRegAddr = 16'h0010; diRead = 1'b1;
    tick(); tick();
    check_val("oor_rdy", 32'(rd_ready), 32'h1);
    check_val("oor_dat", 32'(diRegDataOut), 32'h0);
    // Deselect mid-burst: outputs drop at once, FSM idles
    diEpAddr = 16'h0002;
    #1;
    check_val("desel_dat", 32'(diRegDataOut), 32'h0);
    check_val("desel_rdy", 32'(rd_ready), 32'h0);
    tick();
    diEpAddr = 16'h0001;
    #1;
    check_val("desel_idle", 32'(rd_ready), 32'h0);
    diRead = 1'b0;
    tick();

    // Other endpoint selected: no write, no read
    diEpAddr = 16'h0002; diRegAddr = 16'h0000; diRegDataIn = 16'hFFFF; diWrite = 1'b1;
    tick();
    check_val("ep2_reg0", 32'(rego(0)), 32'h2222);
    check_val("ep2_stb", 32'(reg_wstrobe), 32'h0);
    check_val("ep2_wrdy", 32'(wr_ready), 32'h0);
    diWrite = 1'b0; diRead = 1'b1;
    tick(); tick();
    check_val("ep2_rdy", 32'(rd_ready), 32'h0);
    check_val("ep2_dat", 32'(diRegDataOut), 32'h0);
    diRead = 1'b0; diEpAddr = 16'h0001;
    tick();

    // Stream: 3 words, burst stalls, 4th push resumes
    stream_valid = 1'b1;
    stream_data = 16'hC001; tick();
    stream_data = 16'hC002; tick();
    stream_data = 16'hC003; tick();
    stream_valid = 1'b0;
    check_val("st_cnt3", 32'(fifo_count), 32'd3);
    diRegAddr = 16'h00FF; diRead = 1'b1;
    tick(); tick();
    check_val("st_rdy1", 32'(rd_ready), 32'h1);
    check_val("st_w1", 32'(diRegDataOut), 32'hC001);
    tick();
    check_val("st_w2", 32'(diRegDataOut), 32'hC002);
    tick();
    check_val("st_w3", 32'(diRegDataOut), 32'hC003);
    tick();
    check_val("st_stall", 32'(rd_ready), 32'h0);
    check_val("st_cnt0", 32'(fifo_count), 32'd0);
    tick();
    check_val("st_stall2", 32'(rd_ready), 32'h0);
    stream_data = 16'hC004; stream_valid = 1'b1;
    tick();
    stream_valid = 1'b0;
    check_val("st_push_rdy", 32'(rd_ready), 32'h0);
    tick();
    check_val("st_resume", 32'(rd_ready), 32'h1);
    check_val("st_w4", 32'(diRegDataOut), 32'hC004);
    diRead = 1'b0;
    tick();
    diReset = 1'b1;
    tick();
    diReset = 1'b0;
    check_val("st_flush", 32'(fifo_count), 32'd0);

    // Fill to 512 words, then overflow, then soft reset
    stream_valid = 1'b1;
    for (int i = 0; i < 512; i++) begin
      stream_data = 16'(i);
      tick();
    end
    check_val("fill_cnt", 32'(fifo_count), 32'd512);
    check_val("fill_srdy", 32'(stream_ready), 32'h0);
    check_val("fill_ovf0", 32'(fifo_overflow), 32'h0);
    tick();
    stream_valid = 1'b0;
    check_val("ovf_set", 32'(fifo_overflow), 32'h1);
    check_val("ovf_cnt", 32'(fifo_count), 32'd512);
    diReset = 1'b1;
    tick();
    diReset = 1'b0;
    check_val("dr_cnt", 32'(fifo_count), 32'd0);
    check_val("dr_ovf", 32'(fifo_overflow), 32'h0);
    check_val("dr_srdy", 32'(stream_ready), 32'h1);
    check_val("dr_keep_reg2", 32'(rego(2)), 32'hA5A5);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
